// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-level sequencer for the pong display pipeline.
// Tracks game phase (new game / play / new ball / game over), the number of
// balls in reserve, the post-miss delay timer and, when PONG_SCORE_EN is
// defined, a two-digit BCD score. Without PONG_SCORE_EN the score outputs
// are tied to zero and the hit pulse is not used.
module pong_game_ctrl #(
    parameter int unsigned BALLS        = 3,
    parameter int unsigned TIMER_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       refr_tick,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic       ball_reset,
    output logic [1:0] text_sel,
    output logic [1:0] balls_left,
    output logic [3:0] dig1,
    output logic [3:0] dig0
);

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam logic [1:0] BALLS_INIT = 2'(BALLS);
    localparam logic [6:0] TIMER_LOAD = 7'(TIMER_FRAMES - 1);

    state_t     state_q;
    logic       gra_still_q;
    logic       ball_reset_q;
    logic [1:0] balls_q;
    logic [6:0] timer_q, timer_d;

    logic pressed;
    logic timer_up;
    logic play_miss;

    assign pressed   = (btn != 2'b00);
    assign timer_up  = (timer_q == 7'd0);
    assign play_miss = (state_q == PLAY) && miss;

    // Delay timer next state: reload on a miss in play, else count frames down to zero.
    always_comb begin
        timer_d = timer_q;
        if (play_miss) begin
            timer_d = TIMER_LOAD;
        end else if (refr_tick && !timer_up) begin
            timer_d = timer_q - 7'd1;
        end
    end

    // Delay timer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // Game phase FSM with registered freeze, launch pulse and ball count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= NEWGAME;
            gra_still_q  <= 1'b1;
            ball_reset_q <= 1'b0;
            balls_q      <= BALLS_INIT;
        end else begin
            ball_reset_q <= 1'b0;
            case (state_q)
                NEWGAME: begin
                    balls_q <= BALLS_INIT;
                    if (pressed) begin
                        state_q      <= PLAY;
                        gra_still_q  <= 1'b0;
                        ball_reset_q <= 1'b1;
                        balls_q      <= BALLS_INIT - 2'd1;
                    end
                end
                PLAY: begin
                    if (miss) begin
                        gra_still_q <= 1'b1;
                        if (balls_q == 2'd0) begin
                            state_q <= OVER;
                        end else begin
                            state_q <= NEWBALL;
                            balls_q <= balls_q - 2'd1;
                        end
                    end
                end
                NEWBALL: begin
                    // A press before the timer expires is simply not seen.
                    if (timer_up && pressed) begin
                        state_q      <= PLAY;
                        gra_still_q  <= 1'b0;
                        ball_reset_q <= 1'b1;
                    end
                end
                OVER: begin
                    if (timer_up) begin
                        state_q <= NEWGAME;
                        balls_q <= BALLS_INIT;
                    end
                end
                default: begin
                    state_q     <= NEWGAME;
                    gra_still_q <= 1'b1;
                end
            endcase
        end
    end

    assign gra_still  = gra_still_q;
    assign ball_reset = ball_reset_q;
    assign text_sel   = state_q;
    assign balls_left = balls_q;

`ifdef PONG_SCORE_EN
    logic [3:0] dig1_q, dig1_d;
    logic [3:0] dig0_q, dig0_d;
    logic       play_hit;
    logic       game_restart;

    // A simultaneous miss takes priority, so such a hit never scores.
    assign play_hit     = (state_q == PLAY) && hit && !miss;
    assign game_restart = (state_q == OVER) && timer_up;

    // BCD score next state: clear on game restart, else increment with 99 -> 00 wrap.
    always_comb begin
        dig1_d = dig1_q;
        dig0_d = dig0_q;
        if (game_restart) begin
            dig1_d = '0;
            dig0_d = '0;
        end else if (play_hit) begin
            if (dig0_q == 4'd9) begin
                dig0_d = '0;
                dig1_d = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
            end else begin
                dig0_d = dig0_q + 4'd1;
            end
        end
    end

    // BCD score registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dig1_q <= '0;
            dig0_q <= '0;
        end else begin
            dig1_q <= dig1_d;
            dig0_q <= dig0_d;
        end
    end

    assign dig1 = dig1_q;
    assign dig0 = dig0_q;
`else
    logic unused_hit;
    assign unused_hit = hit;
    assign dig1       = '0;
    assign dig0       = '0;
`endif

endmodule
